// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline stage: FSM state encoding and the
// mapping from state to reported occupancy.
package pipe_stage_elastic_pkg;

    // state    | meaning
    // ST_EMPTY | no beat held, main reg carries BUBBLE
    // ST_ONE   | one beat held in main reg
    // ST_TWO   | main reg plus skid reg both hold beats (SKID=1 builds only)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    function automatic logic [1:0] occupancy_of(input stage_state_t s);
        logic [1:0] occ;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with valid/ready handshake, optional 2-entry skid,
// synchronous flush and hold. Output payload comes only from the main register,
// so there is never a combinational path from in_data_i to out_data_o.
//
// state    | meaning
// ST_EMPTY | nothing held; out_valid_o=0, out_data_o=BUBBLE
// ST_ONE   | one beat in main reg
// ST_TWO   | main reg + skid reg full; upstream is refused
module pipe_stage_elastic #(
    parameter int              DATA_W = 32,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter bit              SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);
    import pipe_stage_elastic_pkg::*;

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              accept;
    logic              pop;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign occupancy_o = occupancy_of(state_q);

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i & ~hold_i;

    // Next-state and main-register load. Hold needs no branch of its own:
    // it forces in_ready_o and pop low, so every state simply stays put.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_load = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept && SKID) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_data;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    // State and main payload register; reset discards any held beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic              ready_q;
            logic [DATA_W-1:0] skid_q;

            // Registered ready: refuse upstream whenever the stage will be full.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_q <= 1'b0;
                end else begin
                    ready_q <= (state_d != ST_TWO);
                end
            end

            // Skid register catches the beat that arrives while downstream stalls.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_q <= '0;
                end else if (flush_i) begin
                    skid_q <= '0;
                end else if (skid_load) begin
                    skid_q <= in_data_i;
                end
            end

            assign skid_data  = skid_q;
            assign in_ready_o = ready_q & ~hold_i & ~flush_i;
        end else begin : g_noskid
            logic alive_q;

            // Keeps in_ready_o low while in reset and until the first clock after it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    alive_q <= 1'b0;
                end else begin
                    alive_q <= 1'b1;
                end
            end

            assign skid_data  = BUBBLE;
            assign in_ready_o = alive_q & ~hold_i & ~flush_i
                              & ((state_q == ST_EMPTY) | out_ready_i);
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: SKID=1 instance (a_*) and SKID=0
// instance (b_*) share one stimulus set. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_pipe_stage_elastic;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;

    int checks = 0;
    int errors = 0;

    pipe_stage_elastic #(.DATA_W(32), .BUBBLE(BUB), .SKID(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush), .hold_i(hold),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .occupancy_o(a_occ)
    );

    pipe_stage_elastic #(.DATA_W(32), .BUBBLE(BUB), .SKID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush), .hold_i(hold),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
        .occupancy_o(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream protocol: a refused beat must stay on in_data until taken.
    logic        pv, pr, pf;
    logic [31:0] pd;
    always @(posedge clk) begin
        if (rst && pv && !pr && !pf && in_valid) begin
            checks++;
            if (in_data !== pd) begin
                errors++;
                $display("FAIL upstream_stable got %h want %h", in_data, pd);
            end
        end
        pv <= in_valid;
        pr <= a_in_ready;
        pf <= flush;
        pd <= in_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
        in_data = 32'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== BUB) begin errors++; $display("FAIL rst_data got %h want %h", a_out_data, BUB); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", a_occ); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_a got %b want 0", a_in_ready); end
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_b got %b want 0", b_in_ready); end
        rst = 1'b1;
        next_cycle();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_a got %b want 1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_b got %b want 1", b_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got %b want 0", a_out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_valid = (i <= 8);
            in_data  = i;
            @(negedge clk);
            if (i == 1) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_first got %b want 0", a_out_valid); end
            end else begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(i - 1))
                    begin errors++; $display("FAIL stream_data got %b/%h want 1/%h", a_out_valid, a_out_data, i - 1); end
                checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL stream_occ got %0d want 1", a_occ); end
            end
            if (i <= 8) begin
                checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready got %b want 1", a_in_ready); end
            end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== BUB || a_occ !== 2'd0)
            begin errors++; $display("FAIL stream_drain got %b/%h/%0d want 0/%h/0", a_out_valid, a_out_data, a_occ, BUB); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got %b want 1", a_in_ready); end
        next_cycle();
        in_data = 32'hB;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %b want 1", a_in_ready); end
        checks++; if (a_out_data !== 32'hA || a_occ !== 2'd1) begin errors++; $display("FAIL bp_one got %h/%0d want a/1", a_out_data, a_occ); end
        next_cycle();
        in_data = 32'hC;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) out_ready = 1'b1;
            @(negedge clk);
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", a_in_ready); end
            checks++; if (a_occ !== 2'd2 || a_out_data !== 32'hA || a_out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_full got %0d/%h/%b want 2/a/1", a_occ, a_out_data, a_out_valid); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (a_out_data !== 32'hB || a_occ !== 2'd1 || a_in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_second got %h/%0d/%b want b/1/1", a_out_data, a_occ, a_in_ready); end
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_data !== 32'hC || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %h/%b want c/1", a_out_data, a_out_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin errors++; $display("FAIL bp_empty got %b/%0d want 0/0", a_out_valid, a_occ); end
        next_cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        next_cycle();
        in_data = 32'h12;
        next_cycle();
        in_data = 32'hD; flush = 1'b1;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", a_in_ready); end
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== BUB) begin errors++; $display("FAIL flush_data got %h want %h", a_out_data, BUB); end
        checks++; if (a_occ !== 2'd0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got %0d/%b want 0/1", a_occ, a_in_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_d got %b want 0", a_out_valid); end
        next_cycle();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hE;
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b1; hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (a_out_data !== 32'hE || a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_data got %h/%b want e/1", a_out_data, a_out_valid); end
            checks++; if (a_in_ready !== 1'b0 || a_occ !== 2'd1) begin errors++; $display("FAIL hold_ctrl got %b/%0d want 0/1", a_in_ready, a_occ); end
            next_cycle();
        end
        hold = 1'b0;
        @(negedge clk);
        checks++; if (a_out_data !== 32'hE || a_in_ready !== 1'b1) begin errors++; $display("FAIL hold_rel got %h/%b want e/1", a_out_data, a_in_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin errors++; $display("FAIL hold_pop_once got %b/%0d want 0/0", a_out_valid, a_occ); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h21;
        next_cycle();
        in_data = 32'h22;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL mid_pre_occ got %0d want 2", a_occ); end
        #2 rst = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== BUB) begin errors++; $display("FAIL mid_rst_out got %b/%h want 0/%h", a_out_valid, a_out_data, BUB); end
        checks++; if (a_in_ready !== 1'b0 || a_occ !== 2'd0) begin errors++; $display("FAIL mid_rst_ctrl got %b/%0d want 0/0", a_in_ready, a_occ); end
        next_cycle();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_occ !== 2'd0)
            begin errors++; $display("FAIL mid_rel got %b/%b/%0d want 1/0/0", a_in_ready, a_out_valid, a_occ); end
    endtask

    task automatic test_skid0();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h31;
        @(negedge clk);
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_ready got %b want 1", b_in_ready); end
        next_cycle();
        in_data = 32'h32;
        @(negedge clk);
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL s0_block got %b want 0", b_in_ready); end
        checks++; if (b_out_data !== 32'h31 || b_occ !== 2'd1) begin errors++; $display("FAIL s0_one got %h/%0d want 31/1", b_out_data, b_occ); end
        out_ready = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb_ready got %b want 1", b_in_ready); end
        next_cycle();
        for (int j = 0; j < 3; j++) begin
            in_valid = (j < 2);
            in_data  = 32'h33 + j;
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h32 + j || b_occ !== 2'd1)
                begin errors++; $display("FAIL s0_stream got %b/%h/%0d want 1/%h/1", b_out_valid, b_out_data, b_occ, 32'h32 + j); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0 || b_out_data !== BUB) begin errors++; $display("FAIL s0_drain got %b/%h want 0/%h", b_out_valid, b_out_data, BUB); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold();
        test_reset_midop();
        test_skid0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
